// File: rtl/trivium_pkg.sv
// Shared widths, warm-up length and loader state encoding for the Trivium key/IV loader.
package trivium_pkg;

    localparam int KEY_W          = 80;
    localparam int IV_W           = 80;
    localparam int TRIVIUM_WARMUP = 1152;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_KEY   = 3'd1,
        LOAD_IV    = 3'd2,
        LOAD_PULSE = 3'd3,
        WARMUP     = 3'd4,
        RUN        = 3'd5
    } loader_state_t;

endpackage

// File: rtl/trivium_byte_collector.sv
// Assembles an N-byte register one byte per write, byte 0 in the least significant lane.
// done_o flags the write that fills the last byte.
module trivium_byte_collector #(
    parameter int N_BYTES = 10,
    parameter int CNT_W   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 wr_en_i,
    input  logic [7:0]           data_i,
    output logic [8*N_BYTES-1:0] value_o,
    output logic                 done_o
);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [8*N_BYTES-1:0] value_q, value_d;
    logic                 at_last_s;

    assign at_last_s = (cnt_q == CNT_W'(N_BYTES - 1));
    assign done_o    = wr_en_i & at_last_s;
    assign value_o   = value_q;

    // Next byte index and byte-lane write; the index holds at the last lane.
    always_comb begin
        cnt_d   = cnt_q;
        value_d = value_q;
        if (clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (wr_en_i) begin
            for (int b = 0; b < N_BYTES; b++) begin
                if (cnt_q == CNT_W'(b)) begin
                    value_d[8*b +: 8] = data_i;
                end else begin
                    value_d[8*b +: 8] = value_q[8*b +: 8];
                end
            end
            if (at_last_s) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Byte index and assembled value registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= {CNT_W{1'b0}};
            value_q <= {(8*N_BYTES){1'b0}};
        end else begin
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/trivium_key_loader.sv
// Byte-serial key/IV loader and init sequencer for a Trivium core.
// Optional build macro TRIVIUM_LOADER_WARMUP_EN adds the WARMUP state and counter.
module trivium_key_loader
    import trivium_pkg::*;
#(
    parameter int KEY_BYTES = KEY_W / 8,
    parameter int IV_BYTES  = IV_W / 8
`ifdef TRIVIUM_LOADER_WARMUP_EN
    ,
    parameter int WARMUP_CYCLES = TRIVIUM_WARMUP
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [8*KEY_BYTES-1:0] key,
    output logic [8*IV_BYTES-1:0]  iv,
    output logic                   core_load,
    output logic                   core_enable,
    output logic                   ks_valid,
    output logic                   busy
);

    localparam int MAX_BYTES  = (KEY_BYTES > IV_BYTES) ? KEY_BYTES : IV_BYTES;
    localparam int BYTE_CNT_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    loader_state_t state_q, state_d;
    logic          xfer_s, clear_s, key_wr_s, iv_wr_s, key_done_s, iv_done_s;
    logic          in_ready_q, in_ready_d;
    logic          core_load_q, core_load_d;
    logic          core_enable_q, core_enable_d;
    logic          ks_valid_q, ks_valid_d;
    logic          busy_q, busy_d;

`ifdef TRIVIUM_LOADER_WARMUP_EN
    localparam int WARM_CNT_W = $clog2(WARMUP_CYCLES + 1);
    logic [WARM_CNT_W-1:0] warm_cnt_q, warm_cnt_d;
`endif

    assign xfer_s = in_valid & in_ready_q;

    trivium_byte_collector #(.N_BYTES(KEY_BYTES), .CNT_W(BYTE_CNT_W)) u_key (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear_s),
        .wr_en_i (key_wr_s),
        .data_i  (in_data),
        .value_o (key),
        .done_o  (key_done_s)
    );

    trivium_byte_collector #(.N_BYTES(IV_BYTES), .CNT_W(BYTE_CNT_W)) u_iv (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear_s),
        .wr_en_i (iv_wr_s),
        .data_i  (in_data),
        .value_o (iv),
        .done_o  (iv_done_s)
    );

    // Next-state logic; start pre-empts every state and drops any concurrent byte.
    always_comb begin
        state_d  = state_q;
        clear_s  = 1'b0;
        key_wr_s = 1'b0;
        iv_wr_s  = 1'b0;
`ifdef TRIVIUM_LOADER_WARMUP_EN
        warm_cnt_d = warm_cnt_q;
`endif
        if (start) begin
            state_d = LOAD_KEY;
            clear_s = 1'b1;
`ifdef TRIVIUM_LOADER_WARMUP_EN
            warm_cnt_d = {WARM_CNT_W{1'b0}};
`endif
        end else begin
            case (state_q)
                IDLE:     state_d = IDLE;
                LOAD_KEY: begin
                    key_wr_s = xfer_s;
                    if (key_done_s) begin
                        state_d = LOAD_IV;
                    end else begin
                        state_d = LOAD_KEY;
                    end
                end
                LOAD_IV: begin
                    iv_wr_s = xfer_s;
                    if (iv_done_s) begin
                        state_d = LOAD_PULSE;
                    end else begin
                        state_d = LOAD_IV;
                    end
                end
`ifdef TRIVIUM_LOADER_WARMUP_EN
                LOAD_PULSE: begin
                    state_d    = WARMUP;
                    warm_cnt_d = {WARM_CNT_W{1'b0}};
                end
                WARMUP: begin
                    if (warm_cnt_q < WARM_CNT_W'(WARMUP_CYCLES)) begin
                        warm_cnt_d = warm_cnt_q + WARM_CNT_W'(1);
                    end else begin
                        warm_cnt_d = warm_cnt_q;
                    end
                    if (warm_cnt_q >= WARM_CNT_W'(WARMUP_CYCLES - 1)) begin
                        state_d = RUN;
                    end else begin
                        state_d = WARMUP;
                    end
                end
`else
                LOAD_PULSE: state_d = RUN;
`endif
                RUN:      state_d = RUN;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Output decode from the next state so every output comes straight off a flop.
    always_comb begin
        in_ready_d    = 1'b0;
        core_load_d   = 1'b0;
        core_enable_d = 1'b0;
        ks_valid_d    = 1'b0;
        busy_d        = 1'b1;
        case (state_d)
            IDLE:       busy_d = 1'b0;
            LOAD_KEY:   in_ready_d = 1'b1;
            LOAD_IV:    in_ready_d = 1'b1;
            LOAD_PULSE: core_load_d = 1'b1;
            WARMUP:     core_enable_d = 1'b1;
            RUN: begin
                core_enable_d = 1'b1;
                ks_valid_d    = 1'b1;
                busy_d        = 1'b0;
            end
            default:    busy_d = 1'b0;
        endcase
    end

    // State, warm-up counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            core_load_q   <= 1'b0;
            core_enable_q <= 1'b0;
            ks_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
`ifdef TRIVIUM_LOADER_WARMUP_EN
            warm_cnt_q    <= {WARM_CNT_W{1'b0}};
`endif
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            core_load_q   <= core_load_d;
            core_enable_q <= core_enable_d;
            ks_valid_q    <= ks_valid_d;
            busy_q        <= busy_d;
`ifdef TRIVIUM_LOADER_WARMUP_EN
            warm_cnt_q    <= warm_cnt_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign core_load   = core_load_q;
    assign core_enable = core_enable_q;
    assign ks_valid    = ks_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_trivium_key_loader.sv
// Directed self-checking bench for trivium_key_loader; honours TRIVIUM_LOADER_WARMUP_EN.
module tb_trivium_key_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, core_load, core_enable, ks_valid, busy;
    logic [79:0] key, iv;

    int pass_cnt  = 0;
    int total_cnt = 0;

`ifdef TRIVIUM_LOADER_WARMUP_EN
    localparam int EXP_LAT = 1153;
`else
    localparam int EXP_LAT = 1;
`endif

    localparam logic [79:0] SEQ_KEY = 80'h09080706050403020100;
    localparam logic [79:0] SEQ_IV  = 80'h13121110_0F0E0D0C0B0A;

    trivium_key_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .key         (key),
        .iv          (iv),
        .core_load   (core_load),
        .core_enable (core_enable),
        .ks_valid    (ks_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte after gap idle cycles and hold it until accepted (bounded).
    task automatic send_byte(input logic [7:0] d, input int gap);
        logic rdy;
        bit   ok;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        in_data  = d;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            rdy = in_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        total_cnt++;
        if (!ok) $display("FAIL send_byte: byte %h not accepted, in_ready=%b required 1", d, in_ready);
        else pass_cnt++;
    endtask

    task automatic load_seq(input int max_gap);
        for (int b = 0; b < 20; b++) send_byte(8'(b), (max_gap == 0) ? 0 : $urandom_range(max_gap, 0));
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick();
        rst = 1'b0;
        total_cnt++;
        if ({in_ready, core_load, core_enable, ks_valid, busy} !== 5'b00000)
            $display("FAIL reset_ctrl: got %b required 00000", {in_ready, core_load, core_enable, ks_valid, busy});
        else pass_cnt++;
        total_cnt++;
        if (key !== 80'h0 || iv !== 80'h0) $display("FAIL reset_keyiv: key=%h iv=%h required 0", key, iv);
        else pass_cnt++;
        // in_valid in IDLE must be ignored
        in_data = 8'h5A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b0 || key !== 80'h0) $display("FAIL idle_ignore: in_ready=%b key=%h required 0/0", in_ready, key);
        else pass_cnt++;
    endtask

    // Check the LOAD_PULSE cycle and measure when ks_valid rises after it.
    task automatic check_pulse_and_latency(input string tag, input logic [79:0] ek, input logic [79:0] ei);
        int lat;
        total_cnt++;
        if (core_load !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL %s_pulse: core_load=%b in_ready=%b busy=%b required 1/0/1", tag, core_load, in_ready, busy);
        else pass_cnt++;
        total_cnt++;
        if (key !== ek || iv !== ei) $display("FAIL %s_keyiv: key=%h iv=%h required %h %h", tag, key, iv, ek, ei);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (core_load !== 1'b0 || core_enable !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL %s_enable: core_load=%b core_enable=%b in_ready=%b required 0/1/0", tag, core_load, core_enable, in_ready);
        else pass_cnt++;
        lat = 1;
        while (ks_valid !== 1'b1 && lat < 1300) begin
            tick();
            lat++;
            if (in_ready !== 1'b0 || core_enable !== 1'b1) begin
                $display("FAIL %s_warm: in_ready=%b core_enable=%b at %0d required 0/1", tag, in_ready, core_enable, lat);
                total_cnt++;
            end
        end
        total_cnt++;
        if (lat !== EXP_LAT) $display("FAIL %s_latency: ks_valid after %0d cycles required %0d", tag, lat, EXP_LAT);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL %s_run: busy=%b in_ready=%b required 0/0", tag, busy, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_load_back_to_back();
        pulse_start();
        total_cnt++;
        if (in_ready !== 1'b1 || busy !== 1'b1) $display("FAIL start_ready: in_ready=%b busy=%b required 1/1", in_ready, busy);
        else pass_cnt++;
        load_seq(0);
        check_pulse_and_latency("b2b", SEQ_KEY, SEQ_IV);
    endtask

    task automatic test_gaps();
        pulse_start();
        load_seq(3);
        check_pulse_and_latency("gaps", SEQ_KEY, SEQ_IV);
    endtask

    task automatic test_restart();
        // start in RUN with a concurrent in_valid
        start = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        tick();
        start = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if (ks_valid !== 1'b0 || core_enable !== 1'b0 || in_ready !== 1'b1 || key !== SEQ_KEY)
            $display("FAIL run_restart: ks_valid=%b core_enable=%b in_ready=%b key=%h required 0/0/1/%h",
                     ks_valid, core_enable, in_ready, key, SEQ_KEY);
        else pass_cnt++;
        for (int b = 0; b < 3; b++) send_byte(8'hFF, 0);
        // start collides with a transfer: byte 0x55 must be dropped
        start = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        tick();
        start = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if (key !== {SEQ_KEY[79:24], 24'hFFFFFF})
            $display("FAIL start_drop: key=%h required %h", key, {SEQ_KEY[79:24], 24'hFFFFFF});
        else pass_cnt++;
        for (int b = 0; b < 20; b++) send_byte(8'hFF, 0);
        check_pulse_and_latency("ones", {80{1'b1}}, {80{1'b1}});
    endtask

    task automatic test_rst_mid();
        pulse_start();
        for (int b = 0; b < 6; b++) send_byte(8'hA0 + 8'(b), 0);
        total_cnt++;
        if (key[47:0] !== 48'hA5A4A3A2A1A0 || key[79:48] !== 32'hFFFFFFFF)
            $display("FAIL partial_key: key=%h required ffffffffa5a4a3a2a1a0", key);
        else pass_cnt++;
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        total_cnt++;
        if (key !== 80'h0 || iv !== 80'h0 || busy !== 1'b0 || in_ready !== 1'b0 || ks_valid !== 1'b0)
            $display("FAIL rst_mid: key=%h iv=%h busy=%b in_ready=%b ks_valid=%b required 0", key, iv, busy, in_ready, ks_valid);
        else pass_cnt++;
        pulse_start();
        load_seq(0);
        check_pulse_and_latency("reload", SEQ_KEY, SEQ_IV);
    endtask

    initial begin
        test_reset();
        test_load_back_to_back();
        test_gaps();
        test_restart();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
